dfm_gate_counter: RTL and testbench
===================================

Name: dfm_gate_counter

Overview:
- Consumer end of the preset-gate interface in the digital frequency meter (DFM).
- Takes the square preset gate `gatein` from the gate generator and an asynchronous measured signal `sig_in`.
- Implements an equal-precision (reciprocal) measurement. The actual gate opens on the first `sig_in` rising edge after `gatein` rises, and closes on the first `sig_in` rising edge after `gatein` falls.
- Reports the Sys_CLK count and signal-period count over the actual gate, so downstream logic computes f = f_clk × sig_cnt / ref_cnt.

Parameters:
- CNT_W, 32, width of both result counters.
- TIMEOUT, 60_000_000, Sys_CLK cycles without a `sig_in` rising edge (in ARMED or MEAS) before a no-signal result is declared.

Ports:
- Sys_CLK  input  1  system clock; all logic on its rising edge.
- Sys_RST  input  1  reset, asynchronous, active-high.
- gatein  input  1  preset gate, synchronous to Sys_CLK.
- sig_in  input  1  measured signal, asynchronous to Sys_CLK.
- ref_cnt_o  output  CNT_W  Sys_CLK cycles spanned by the actual gate.
- sig_cnt_o  output  CNT_W  complete `sig_in` periods within the actual gate.
- valid  output  1  one-cycle pulse; result outputs updated in the same cycle.
- nosig  output  1  last result was a timeout; holds until the next valid.
- ovf  output  1  `ref_cnt` saturated during the last result; holds until the next valid.
- busy  output  1  actual gate open (state MEAS).

Behaviour:
- Reset (async, any state): state=WAIT_LOW; all counters, synchronizer flops, and outputs = 0.
- Synchronizer:
  - `sig_in` passes through a 3-flop chain s0→s1→s2.
  - `rise` = s1 & ~s2. Delay is identical for opening and closing edges, so it cancels.
- FSM states:
  - WAIT_LOW: if `gatein`==0 → ARMED. Guarantees no partial gate after reset.
  - ARMED:
    - If `gatein`==1 & `rise` → MEAS; ref_cnt=0, sig_cnt=0, tmo=0 (opening cycle t0).
    - If `gatein` stays 0, wait.
  - MEAS (busy=1):
    - Each cycle: ref_cnt += 1, saturating at all-ones; on saturation set internal ovf_r.
    - If `rise` & `gatein`==1: sig_cnt += 1.
    - If `rise` & `gatein`==0 (closing cycle t1):
      - ref_cnt_o ← ref_cnt+1 (saturating), i.e. t1−t0; sig_cnt_o ← sig_cnt+1.
      - ovf ← ovf_r; nosig ← 0; valid=1.
      - Next state = ARMED. If `gatein` is already high again, the next opening needs a fresh rise. No WAIT_LOW is required because the closing edge has `gatein`==0.
  - Timeout (ARMED or MEAS):
    - tmo increments each cycle and clears on every `rise`.
    - If tmo reaches TIMEOUT-1: ref_cnt_o=0, sig_cnt_o=0, nosig=1, ovf=0, valid=1; → WAIT_LOW.
- Simultaneous events:
  - `rise` in the same cycle `gatein` falls counts as the closing edge.
  - `rise` in the same cycle `gatein` rises (ARMED) opens the gate.
  - Timeout and `rise` in the same cycle: `rise` wins and tmo clears.
- sig_cnt saturates at all-ones and also sets ovf_r.
- Latency: valid is asserted in the cycle the closing `rise` is detected, i.e. 3 Sys_CLK after the `sig_in` edge.
- Outputs ref_cnt_o and sig_cnt_o hold between valid pulses.

Test Plan:
1. Sys_CLK period 10 ns, `sig_in` period 100 ns (10 clocks), `gatein` 100 cycles high / 100 low, any phase → every valid gives sig_cnt_o=10, ref_cnt_o=100, nosig=0, ovf=0.
2. `sig_in` period 7 clocks, same gate → ref_cnt_o = 7×sig_cnt_o with sig_cnt_o ∈ {14,15}; busy is high exactly ref_cnt_o cycles.
3. TIMEOUT=500, `sig_in` held 0, `gatein` toggling → valid with both counts 0 and nosig=1 at cycle 500 of ARMED. Restore `sig_in` → next result is normal and nosig clears.
4. Release reset while `gatein`=1 and `sig_in` toggling → no busy until `gatein` has gone low then high; the first result is full length (test 1 values).
5. Assert Sys_RST mid-MEAS, asynchronously between clock edges → busy/valid/outputs go to 0 immediately; after release the first valid is a complete 10/100 result.
6. CNT_W=8, gate 300 cycles, `sig_in` period 10 → ref_cnt_o=255, ovf=1, sig_cnt_o=30; the next result with a 100-cycle gate clears ovf.

Source files
------------

// File: rtl/dfm_gate_counter.sv
// Reciprocal-count frequency meter core: aligns the preset gate to sig_in rising edges and
// reports Sys_CLK and sig_in period counts over the aligned gate, with a no-signal timeout.
`timescale 1ns/1ps
module dfm_gate_counter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 60_000_000
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic             gatein,
  input  logic             sig_in,
  output logic [CNT_W-1:0] ref_cnt_o,
  output logic [CNT_W-1:0] sig_cnt_o,
  output logic             valid,
  output logic             nosig,
  output logic             ovf,
  output logic             busy
);

  localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {WAIT_LOW, ARMED, MEAS} state_t;

  state_t            state, state_nxt;
  logic [2:0]        sync_q;
  logic              rise;
  logic [CNT_W-1:0]  ref_cnt, ref_nxt, sig_cnt, sig_nxt;
  logic [CNT_W-1:0]  ref_inc, sig_inc;
  logic              ref_sat, sig_sat;
  logic [TMO_W-1:0]  tmo, tmo_nxt, tmo_step;
  logic              tmo_hit;
  logic              ovf_r, ovf_r_nxt;
  logic [CNT_W-1:0]  ref_o_nxt, sig_o_nxt;
  logic              valid_nxt, nosig_nxt, ovf_nxt;

  // Same synchronizer latency on opening and closing edges, so it cancels out of the span.
  assign rise    = sync_q[1] & ~sync_q[2];
  assign ref_sat = (ref_cnt == CNT_MAX);
  assign sig_sat = (sig_cnt == CNT_MAX);
  assign ref_inc = ref_sat ? ref_cnt : ref_cnt + CNT_W'(1);
  assign sig_inc = sig_sat ? sig_cnt : sig_cnt + CNT_W'(1);
  assign tmo_step = rise ? '0 : tmo + TMO_W'(1);
  assign tmo_hit  = (tmo == TMO_LAST) & ~rise;
  assign busy     = (state == MEAS);

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      state     <= WAIT_LOW;
      sync_q    <= '0;
      ref_cnt   <= '0;
      sig_cnt   <= '0;
      tmo       <= '0;
      ovf_r     <= 1'b0;
      ref_cnt_o <= '0;
      sig_cnt_o <= '0;
      valid     <= 1'b0;
      nosig     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_q    <= {sync_q[1:0], sig_in};
      ref_cnt   <= ref_nxt;
      sig_cnt   <= sig_nxt;
      tmo       <= tmo_nxt;
      ovf_r     <= ovf_r_nxt;
      ref_cnt_o <= ref_o_nxt;
      sig_cnt_o <= sig_o_nxt;
      valid     <= valid_nxt;
      nosig     <= nosig_nxt;
      ovf       <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_cnt;
    sig_nxt   = sig_cnt;
    tmo_nxt   = tmo;
    ovf_r_nxt = ovf_r;
    ref_o_nxt = ref_cnt_o;
    sig_o_nxt = sig_cnt_o;
    valid_nxt = 1'b0;
    nosig_nxt = nosig;
    ovf_nxt   = ovf;
    case (state)
      WAIT_LOW: begin
        tmo_nxt = '0;
        if (!gatein) state_nxt = ARMED;
      end
      ARMED: begin
        tmo_nxt = tmo_step;
        if (gatein && rise) begin
          state_nxt = MEAS;
          ref_nxt   = '0;
          sig_nxt   = '0;
          ovf_r_nxt = 1'b0;
          tmo_nxt   = '0;
        end else if (tmo_hit) begin
          state_nxt = WAIT_LOW;
          tmo_nxt   = '0;
          ref_o_nxt = '0;
          sig_o_nxt = '0;
          nosig_nxt = 1'b1;
          ovf_nxt   = 1'b0;
          valid_nxt = 1'b1;
        end
      end
      MEAS: begin
        tmo_nxt   = tmo_step;
        ref_nxt   = ref_inc;
        ovf_r_nxt = ovf_r | ref_sat;
        if (rise && gatein) begin
          sig_nxt   = sig_inc;
          ovf_r_nxt = ovf_r | ref_sat | sig_sat;
        end else if (rise) begin
          // Closing edge: this cycle itself belongs to the span, hence the +1 on both counts.
          state_nxt = ARMED;
          ref_o_nxt = ref_inc;
          sig_o_nxt = sig_inc;
          ovf_nxt   = ovf_r | ref_sat | sig_sat;
          nosig_nxt = 1'b0;
          valid_nxt = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = WAIT_LOW;
          tmo_nxt   = '0;
          ref_o_nxt = '0;
          sig_o_nxt = '0;
          nosig_nxt = 1'b1;
          ovf_nxt   = 1'b0;
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

endmodule

// File: tb/tb_dfm_gate_counter.sv
// Directed bench for dfm_gate_counter: scoreboard of expected results popped on each valid.
`timescale 1ns/1ps
module tb_dfm_gate_counter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 500;

  logic             Sys_CLK, Sys_RST, gatein, sig_in;
  logic [CNT_W-1:0] ref_cnt_o, sig_cnt_o;
  logic             valid, nosig, ovf, busy;

  dfm_gate_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .gatein(gatein), .sig_in(sig_in),
    .ref_cnt_o(ref_cnt_o), .sig_cnt_o(sig_cnt_o), .valid(valid), .nosig(nosig),
    .ovf(ovf), .busy(busy)
  );

  // kind 0: exact counts; kind 1: period-7 ratio result (ref = 7*sig, sig in {14,15})
  typedef struct {
    int kind;
    int ref_v;
    int sig_v;
    int nosig_v;
    int ovf_v;
    int busy_v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   last_vcyc = -1;
  int   half_ns = 50;
  logic sig_en = 1'b1;

  initial Sys_CLK = 1'b0;
  always #5 Sys_CLK = ~Sys_CLK;

  // Edges land on a 3/8 ns grid, never on a 5 ns posedge.
  initial begin
    sig_in = 1'b0;
    #3;
    forever begin
      #(half_ns);
      sig_in = sig_en ? ~sig_in : 1'b0;
    end
  end

  initial forever begin
    @(posedge Sys_CLK);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int kind, input int r, input int s, input int ns, input int ov,
                          input int b);
    exp_t e;
    e.kind = kind; e.ref_v = r; e.sig_v = s; e.nosig_v = ns; e.ovf_v = ov; e.busy_v = b;
    sb.push_back(e);
  endtask

  task automatic drive_gate(input logic lvl, input int n);
    @(posedge Sys_CLK);
    #1 gatein = lvl;
    repeat (n - 1) @(posedge Sys_CLK);
  endtask

  task automatic do_reset(input int half);
    @(negedge Sys_CLK);
    Sys_RST = 1'b1;
    gatein  = 1'b0;
    half_ns = half;
    sb.delete();
    repeat (10) @(posedge Sys_CLK);
    @(negedge Sys_CLK);
    Sys_RST = 1'b0;
  endtask

  // Monitor: pop one expectation per valid pulse.
  initial forever begin
    exp_t e;
    @(negedge Sys_CLK);
    if (Sys_RST) busy_cnt = 0;
    else if (valid) begin
      last_vcyc = cyc;
      check("valid_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("nosig", nosig, e.nosig_v);
        check("ovf", ovf, e.ovf_v);
        if (e.kind == 0) begin
          check("ref_cnt", ref_cnt_o, e.ref_v);
          check("sig_cnt", sig_cnt_o, e.sig_v);
          check("busy_cycles", busy_cnt, e.busy_v);
        end else begin
          check("sig_cnt_range", (sig_cnt_o == 14 || sig_cnt_o == 15), 1);
          check("ref_eq_7x_sig", ref_cnt_o, 7 * int'(sig_cnt_o));
          check("busy_eq_ref", busy_cnt, int'(ref_cnt_o));
        end
      end
      busy_cnt = 0;
    end else if (busy) busy_cnt++;
  end

  initial begin
    int   rel;
    logic busy_seen;
    Sys_RST = 1'b1;
    gatein  = 1'b0;
    repeat (3) @(posedge Sys_CLK);
    #1;
    check("rst_ref", ref_cnt_o, 0);
    check("rst_sig", sig_cnt_o, 0);
    check("rst_valid", valid, 0);
    check("rst_nosig", nosig, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);

    // Release with gate already high: that partial gate must be ignored.
    gatein = 1'b1;
    @(negedge Sys_CLK);
    Sys_RST = 1'b0;
    busy_seen = 1'b0;
    repeat (60) begin
      @(posedge Sys_CLK);
      #1;
      if (busy) busy_seen = 1'b1;
    end
    check("no_busy_partial_gate", busy_seen, 0);
    drive_gate(0, 100);
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 100, 10, 0, 0, 100);
      drive_gate(1, 100);
      drive_gate(0, 100);
    end
    check("hold_ref", ref_cnt_o, 100);
    check("hold_sig", sig_cnt_o, 10);

    // Period 7 clocks.
    do_reset(35);
    drive_gate(0, 20);
    for (int i = 0; i < 4; i++) begin
      push_exp(1, 0, 0, 0, 0, 0);
      drive_gate(1, 100);
      drive_gate(0, 100);
    end

    // Asynchronous reset in the middle of a measurement.
    do_reset(50);
    drive_gate(0, 20);
    push_exp(0, 100, 10, 0, 0, 100);
    drive_gate(1, 100);
    drive_gate(0, 100);
    drive_gate(1, 50);
    @(negedge Sys_CLK);
    #2;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ref", ref_cnt_o, 100);
    Sys_RST = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_ref", ref_cnt_o, 0);
    check("async_rst_sig", sig_cnt_o, 0);
    sb.delete();
    repeat (3) @(posedge Sys_CLK);
    @(negedge Sys_CLK);
    #2 Sys_RST = 1'b0;
    drive_gate(1, 30);
    drive_gate(0, 100);
    push_exp(0, 100, 10, 0, 0, 100);
    drive_gate(1, 100);
    drive_gate(0, 100);

    // No signal: timeout after 500 ARMED cycles, then recovery.
    sig_en = 1'b0;
    do_reset(50);
    rel = cyc;
    push_exp(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_gate(0, 100);
      drive_gate(1, 100);
    end
    check("timeout_latency", last_vcyc - rel, 501);
    check("nosig_hold", nosig, 1);
    sig_en = 1'b1;
    push_exp(0, 100, 10, 0, 0, 100);
    drive_gate(0, 100);
    drive_gate(1, 100);
    drive_gate(0, 100);
    check("nosig_cleared", nosig, 0);

    // Long gate saturates the 8-bit reference counter.
    do_reset(50);
    drive_gate(0, 20);
    push_exp(0, 255, 30, 0, 1, 300);
    drive_gate(1, 300);
    drive_gate(0, 100);
    check("ovf_hold", ovf, 1);
    push_exp(0, 100, 10, 0, 0, 100);
    drive_gate(1, 100);
    drive_gate(0, 100);

    repeat (20) @(posedge Sys_CLK);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
